imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of `mips_single_cycle`. It receives a framed byte stream through a valid/ready handshake and packs the bytes into 32-bit big-endian words. It writes those words into the processor's instruction memory starting at word 0, and holds the processor in reset until the full image is written and its checksum has been verified.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 46 ++++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time program loader.
//   state_t        loader FSM states
//   ERR_*          err_code encodings
//   len_too_big()  image length check against instruction-memory capacity
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  // True when a frame of n words cannot fit in 2^addr_w words of memory.
  function automatic logic len_too_big(input logic [15:0] n, input int addr_w);
    return ({1'b0, n} > (17'd1 << addr_w));
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: packs an MSB-first byte stream into 32-bit words.
//   clk, rst_n     clock, async active-low reset
//   clear          synchronous re-arm (drops any partial word)
//   byte_valid     byte_in is consumed this cycle
//   byte_in        stream byte
//   last_byte      combinational: the byte being consumed completes a word
//   word_valid     one-cycle pulse, the cycle after the 4th byte is consumed
//   word           completed word, held until the next word completes
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sh;   // first three bytes of the word in flight

  assign last_byte = byte_valid && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      sh         <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else if (clear) begin
      cnt        <= 2'd0;
      sh         <= 24'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_byte;
      if (byte_valid) begin
        cnt <= cnt + 2'd1;
        sh  <= {sh[15:0], byte_in};
        // word only moves on completion so it stays stable through the write
        if (cnt == 2'd3) word <= {sh, byte_in};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader in front of mips_single_cycle. Accepts a
// framed byte stream {LEN_HI, LEN_LO, 4*N data bytes, CSUM}, writes the
// big-endian words to instruction memory from word 0, and holds the CPU in
// reset until the whole image is written and the XOR checksum matches.
//   clk, reset      clock, async active-low reset
//   in_valid/ready  byte handshake; in_data is the stream byte
//   restart         one-cycle pulse re-arming the loader from DONE/ERR
//   imem_we/addr/wdata  instruction-memory write port (one cycle per word)
//   cpu_reset       active-high reset to the processor
//   done/error/err_code  load status (sticky until restart)
//   words_loaded    number of words written so far
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state;
  logic [7:0]        len_hi;
  logic [7:0]        xor_acc;
  logic [ADDR_W:0]   len;     // words expected
  logic [ADDR_W:0]   wcnt;    // words fully received
  logic [15:0]       len_in;
  logic              accept;
  logic              rearm;
  logic              last_byte;

  assign in_ready = (state == LEN_HI) || (state == LEN_LO) ||
                    (state == DATA)   || (state == CSUM);
  assign accept   = in_valid && in_ready;
  assign rearm    = restart && ((state == DONE) || (state == ERR));
  assign len_in   = {len_hi, in_data};

  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (rearm),
    .byte_valid (accept && (state == DATA)),
    .byte_in    (in_data),
    .last_byte  (last_byte),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LEN_HI;
      len_hi       <= 8'd0;
      xor_acc      <= 8'd0;
      len          <= '0;
      wcnt         <= '0;
      imem_addr    <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      // Address advances once the write cycle completes. Holding at the top
      // address covers the full-capacity image without wrapping to 0.
      if (imem_we) begin
        words_loaded <= words_loaded + 1'b1;
        if (imem_addr != {ADDR_W{1'b1}}) imem_addr <= imem_addr + 1'b1;
      end

      case (state)
        LEN_HI: if (accept) begin
          len_hi  <= in_data;
          xor_acc <= xor_acc ^ in_data;
          state   <= LEN_LO;
        end

        LEN_LO: if (accept) begin
          xor_acc <= xor_acc ^ in_data;
          if (len_too_big(len_in, ADDR_W)) begin
            state    <= ERR;
            error    <= 1'b1;
            err_code <= ERR_LEN;
          end else if (len_in == 16'd0) begin
            state <= CSUM;
          end else begin
            len   <= (ADDR_W+1)'(len_in);
            state <= DATA;
          end
        end

        DATA: if (accept) begin
          xor_acc <= xor_acc ^ in_data;
          if (last_byte) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt + 1'b1 == len) state <= CSUM;
          end
        end

        // The last word's write pulse overlaps this state at the latest, so
        // releasing the CPU here is always after the final write.
        CSUM: if (accept) begin
          if (in_data == xor_acc) begin
            state     <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state    <= ERR;
            error    <= 1'b1;
            err_code <= ERR_CSUM;
          end
        end

        DONE, ERR: if (restart) begin
          state        <= LEN_HI;
          len_hi       <= 8'd0;
          xor_acc      <= 8'd0;
          len          <= '0;
          wcnt         <= '0;
          imem_addr    <= '0;
          words_loaded <= '0;
          cpu_reset    <= 1'b1;
          done         <= 1'b0;
          error        <= 1'b0;
          err_code     <= ERR_NONE;
        end

        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frame scenarios plus
// hand-written sequences for async reset mid-load and restart/valid overlap.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    int          nw;
    logic [7:0]  flip;
    bit          gaps;
    bit          exp_done;
    logic [1:0]  exp_err;
    int          exp_words;
  } vec_t;

  logic [31:0] prog [10] = '{
    32'h20090005, 32'h200A000A, 32'h012A5820, 32'h016A6022, 32'h018B6824,
    32'h01AC7025, 32'hAC0E0000, 32'h8C0F0000, 32'h11EE0001, 32'h08000000
  };

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];
  logic              prev_we = 1'b0;

  // Write monitor: logs every write, flags multi-cycle pulses and writes
  // while the CPU is already released.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      n_cmp++;
      if (prev_we || !cpu_reset) begin
        n_bad++;
        $display("FAIL we_pulse: prev_we=%0b cpu_reset=%0b, required prev_we=0 cpu_reset=1",
                 prev_we, cpu_reset);
      end
    end
    prev_we = imem_we;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Call in the phase just after a rising edge.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: in_ready=0 after 20 cycles, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  task automatic do_restart();
    sync();
    restart = 1'b1;
    sync();
    restart = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_code", err_code, 0);
    chk("rst_cpu", cpu_reset, 1);
    chk("rst_words", words_loaded, 0);
    chk("rst_ready", in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  cs, b;
    logic [31:0] w;
    sync();
    wr_addr.delete();
    wr_data.delete();
    cs = 8'd0;
    b = v.n[15:8]; send(b); cs ^= b;
    b = v.n[7:0];  send(b); cs ^= b;
    if (v.exp_err == 2'b01) begin
      @(negedge clk);
      chk("len_error", error, 1);
      chk("len_code", err_code, 2'b01);
      chk("len_ready", in_ready, 0);
      chk("len_cpu", cpu_reset, 1);
      chk("len_nowrites", wr_addr.size(), 0);
    end else begin
      for (int k = 0; k < v.nw; k++) begin
        w = prog[k];
        for (int j = 3; j >= 0; j--) begin
          if (v.gaps) gap();
          b = w[j*8 +: 8];
          send(b);
          cs ^= b;
        end
      end
      if (v.gaps) gap();
      send(cs ^ v.flip);
      @(negedge clk);
      chk("end_done", done, v.exp_done);
      chk("end_error", error, !v.exp_done);
      chk("end_code", err_code, v.exp_err);
      chk("end_cpu", cpu_reset, !v.exp_done);
      chk("end_words", words_loaded, v.exp_words);
      chk("end_ready", in_ready, 0);
      chk("wr_count", wr_addr.size(), v.exp_words);
      for (int k = 0; k < wr_addr.size() && k < v.exp_words; k++) begin
        chk($sformatf("wr_addr[%0d]", k), wr_addr[k], k);
        chk($sformatf("wr_data[%0d]", k), wr_data[k], prog[k]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    vec_t one;
    //          n       nw  flip  gaps done err    words
    tbl[0] = '{16'd2,   2,  8'h00, 0,  1,  2'b00, 2};
    tbl[1] = '{16'd2,   2,  8'h01, 0,  0,  2'b10, 2};
    tbl[2] = '{16'd2,   2,  8'h00, 0,  1,  2'b00, 2};
    tbl[3] = '{16'd257, 0,  8'h00, 0,  0,  2'b01, 0};
    tbl[4] = '{16'd0,   0,  8'h00, 0,  1,  2'b00, 0};
    tbl[5] = '{16'd10,  10, 8'h00, 0,  1,  2'b00, 10};
    tbl[6] = '{16'd10,  10, 8'h00, 1,  1,  2'b00, 10};

    reset = 1'b0; in_valid = 1'b0; in_data = 8'd0; restart = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_we", imem_we, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_wdata", imem_wdata, 0);
    chk("reset_cpu", cpu_reset, 1);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_code", err_code, 0);
    chk("reset_words", words_loaded, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i]);
      do_restart();
    end

    // Async reset after 5 data bytes of an N=3 frame.
    sync();
    wr_addr.delete(); wr_data.delete();
    send(8'h00); send(8'h03);
    send(8'h20); send(8'h09); send(8'h00); send(8'h05); send(8'h20);
    chk("mid_words", words_loaded, 1);
    chk("mid_addr", imem_addr, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_cpu", cpu_reset, 1);
    chk("arst_we", imem_we, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_wdata", imem_wdata, 0);
    chk("arst_words", words_loaded, 0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(tbl[0]);

    // restart and a byte offered together in DONE: the byte must be dropped.
    sync();
    restart = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    sync();
    restart = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("ovl_done", done, 0);
    chk("ovl_cpu", cpu_reset, 1);
    chk("ovl_ready", in_ready, 1);
    one = '{16'd1, 1, 8'h00, 0, 1, 2'b00, 1};
    run_vec(one);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
